dmem_arbiter: RTL and testbench



---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_arbiter_if.sv | 21 ++
 rtl/rr_arb2.sv | 48 ++++
 rtl/dmem_arbiter.sv | 95 +++++++++
 tb/tb_dmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice: default widths and the
// grant-owner type used by the round-robin arbiter.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 16;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request/command toward the
// arbiter, grant and registered read return back to the requester.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (output req, we, addr, wdata, input gnt, rdata, rvalid);
    modport slave  (input req, we, addr, wdata, output gnt, rdata, rvalid);

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a last-grant flop; the hold_b input lets
// requester B keep a grant it already owns (used for locked bursts).
module rr_arb2
    import dmem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic hold_b,
    output logic gnt_a,
    output logic gnt_b
);

    owner_e last_gnt;

    always_comb begin
        // NOTE: both grants get a default before any branch, so no path leaves
        // them unassigned and no latch is inferred.
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            if (hold_b && req_b && last_gnt == OWN_B) begin
                gnt_b = 1'b1;
            end else if (req_a && req_b) begin
                gnt_a = (last_gnt == OWN_B);
                gnt_b = (last_gnt == OWN_A);
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    // Reset to OWN_B so that A wins the first conflict.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before the edge.
        if (rst) begin
            last_gnt <= OWN_B;
        end else if (gnt_a) begin
            last_gnt <= OWN_A;
        end else if (gnt_b) begin
            last_gnt <= OWN_B;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer between the MEM stage (port A) and the loader (port B) in
// front of the 256x16 data memory. Define DMEM_ARB_LOCK_EN to add b_lock.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     a,
    dmem_arbiter_if.slave     b,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              b_lock,
`endif
    output logic              stall_a,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              gnt_a;
    logic              gnt_b;
    logic              hold_b;
    logic              a_rvalid_q;
    logic              b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

`ifdef DMEM_ARB_LOCK_EN
    assign hold_b = b_lock;
`else
    assign hold_b = 1'b0;
`endif

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_a  (a.req),
        .req_b  (b.req),
        .hold_b (hold_b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b)
    );

    assign a.gnt    = gnt_a;
    assign b.gnt    = gnt_b;
    assign a.rvalid = a_rvalid_q;
    assign b.rvalid = b_rvalid_q;
    assign a.rdata  = a_rdata_q;
    assign b.rdata  = b_rdata_q;
    assign stall_a  = a.req & ~gnt_a;

    // Grants are one-hot or zero, so mem_write and mem_read can never both be set.
    always_comb begin
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_a) begin
            mem_write = a.we;
            mem_read  = ~a.we;
            mem_addr  = a.addr;
            mem_wdata = a.wdata;
        end else if (gnt_b) begin
            mem_write = b.we;
            mem_read  = ~b.we;
            mem_addr  = b.addr;
            mem_wdata = b.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            conflict_cnt <= '0;
        end else begin
            a_rvalid_q <= gnt_a & ~a.we;
            b_rvalid_q <= gnt_b & ~b.we;
            if (gnt_a && !a.we) a_rdata_q <= mem_rdata;
            if (gnt_b && !b.we) b_rdata_q <= mem_rdata;
            if (a.req && b.req && conflict_cnt != {CNT_W{1'b1}}) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, checked
// against a cycle-level reference model holding its own copy of memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_a;
    logic        mem_write;
    logic        mem_read;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [7:0]  conflict_cnt;
`ifdef DMEM_ARB_LOCK_EN
    logic        b_lock;
`endif

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) a_if ();
    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) b_if ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a_if),
        .b            (b_if),
`ifdef DMEM_ARB_LOCK_EN
        .b_lock       (b_lock),
`endif
        .stall_a      (stall_a),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the clock edge, preload mem[i] = i on reset.
    logic [15:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: who won last, pending read returns, counter, memory image.
    int          m_last;
    int          m_cnt;
    logic        m_arv, m_brv;
    logic [15:0] m_ard, m_brd;
    logic [15:0] ref_mem [256];
    logic        obs_ga, obs_gb, obs_stall;
    logic        exp_ga, exp_gb;

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic step();
        logic        lock_on;
        logic        e_w, e_r;
        logic [7:0]  e_addr;
        logic [15:0] e_wdata;
        #3;
        lock_on = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        lock_on = b_lock && b_if.req && (m_last == 1);
`endif
        exp_ga = 1'b0;
        exp_gb = 1'b0;
        if (!rst) begin
            if (lock_on) exp_gb = 1'b1;
            else if (a_if.req && b_if.req) begin
                exp_ga = (m_last == 1);
                exp_gb = (m_last == 0);
            end else begin
                exp_ga = a_if.req;
                exp_gb = b_if.req;
            end
        end
        e_w     = (exp_ga && a_if.we) || (exp_gb && b_if.we);
        e_r     = (exp_ga && !a_if.we) || (exp_gb && !b_if.we);
        e_addr  = exp_ga ? a_if.addr  : (exp_gb ? b_if.addr  : 8'h00);
        e_wdata = exp_ga ? a_if.wdata : (exp_gb ? b_if.wdata : 16'h0000);
        obs_ga    = a_if.gnt;
        obs_gb    = b_if.gnt;
        obs_stall = stall_a;
        check("a_gnt", a_if.gnt, exp_ga);
        check("b_gnt", b_if.gnt, exp_gb);
        check("stall_a", stall_a, a_if.req && !exp_ga);
        check("mem_write", mem_write, e_w);
        check("mem_read", mem_read, e_r);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);

        if (rst) begin
            m_last = 1; m_cnt = 0;
            m_arv = 1'b0; m_brv = 1'b0; m_ard = 16'h0; m_brd = 16'h0;
            for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i);
        end else begin
            m_arv = exp_ga && !a_if.we;
            m_brv = exp_gb && !b_if.we;
            if (m_arv) m_ard = ref_mem[a_if.addr];
            if (m_brv) m_brd = ref_mem[b_if.addr];
            if (exp_ga && a_if.we) ref_mem[a_if.addr] = a_if.wdata;
            if (exp_gb && b_if.we) ref_mem[b_if.addr] = b_if.wdata;
            if (exp_ga) m_last = 0;
            else if (exp_gb) m_last = 1;
            if (a_if.req && b_if.req && m_cnt < 255) m_cnt++;
        end

        @(posedge clk);
        #1;
        check("a_rvalid", a_if.rvalid, m_arv);
        check("b_rvalid", b_if.rvalid, m_brv);
        check("a_rdata", a_if.rdata, m_ard);
        check("b_rdata", b_if.rdata, m_brd);
        check("conflict_cnt", conflict_cnt, m_cnt);
    endtask

    task automatic idle_inputs();
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = 8'h00; a_if.wdata = 16'h0000;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = 8'h00; b_if.wdata = 16'h0000;
`ifdef DMEM_ARB_LOCK_EN
        b_lock = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic a_hold, b_hold;

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_last = 1; m_cnt = 0;
        m_arv = 1'b0; m_brv = 1'b0; m_ard = 16'h0; m_brd = 16'h0;
        @(posedge clk);
        #1;
        do_reset();
        check("reset_cnt", conflict_cnt, 0);
        check("reset_a_rvalid", a_if.rvalid, 0);

        // A-only read of preloaded address 0x05.
        a_if.req = 1'b1; a_if.addr = 8'h05;
        step();
        check("t1_gnt", obs_ga, 1);
        check("t1_stall", obs_stall, 0);
        check("t1_rvalid", a_if.rvalid, 1);
        check("t1_rdata", a_if.rdata, 16'h0005);
        idle_inputs();
        step();
        check("t1_rvalid_once", a_if.rvalid, 0);

        // B writes 0xBEEF to 0x10, A reads it back.
        b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 8'h10; b_if.wdata = 16'hBEEF;
        step();
        check("t2_bwrite_no_rvalid", b_if.rvalid, 0);
        idle_inputs();
        a_if.req = 1'b1; a_if.addr = 8'h10;
        step();
        check("t2_rdata", a_if.rdata, 16'hBEEF);
        idle_inputs();

        // Four cycles of conflict: A, B, A, B.
        do_reset();
        a_if.req = 1'b1; a_if.addr = 8'h03;
        b_if.req = 1'b1; b_if.addr = 8'h07;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_gnt_a", obs_ga, (k % 2) == 0);
            check("t3_gnt_b", obs_gb, (k % 2) == 1);
            check("t3_stall", obs_stall, (k % 2) == 1);
        end
        check("t3_cnt", conflict_cnt, 4);

        // Continuous conflict saturates the counter.
        for (int k = 0; k < 300; k++) step();
        check("t4_saturate", conflict_cnt, 255);

        // Reset lands on a would-be A read; next conflict goes to A.
        idle_inputs();
        a_if.req = 1'b1; a_if.addr = 8'h05;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_gnt_in_reset", obs_ga, 0);
        check("t5_no_rvalid", a_if.rvalid, 0);
        check("t5_cnt_cleared", conflict_cnt, 0);
        b_if.req = 1'b1; b_if.addr = 8'h06;
        step();
        check("t5_first_conflict_a", obs_ga, 1);
        idle_inputs();
        step();

`ifdef DMEM_ARB_LOCK_EN
        // Locked three-word B burst while A waits.
        do_reset();
        a_if.req = 1'b1; a_if.addr = 8'h01;
        b_if.req = 1'b1; b_if.we = 1'b1; b_lock = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b_if.addr = 8'(8'h20 + k); b_if.wdata = 16'(16'hA000 + k);
            step();
            check("t6_lock_gnt_b", obs_gb, 1);
            check("t6_lock_stall", obs_stall, 1);
        end
        b_lock = 1'b0;
        step();
        check("t6_unlock_gnt_a", obs_ga, 1);
        idle_inputs();
        step();
`endif

        // Randomized traffic; a requester holds its command until granted.
        do_reset();
        a_hold = 1'b0;
        b_hold = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (!a_hold || $urandom_range(0, 9) == 0) begin
                a_if.req   = ($urandom_range(0, 99) < 60);
                a_if.we    = $urandom_range(0, 1) == 1;
                a_if.addr  = 8'($urandom_range(0, 31));
                a_if.wdata = 16'($urandom);
            end
            if (!b_hold || $urandom_range(0, 9) == 0) begin
                b_if.req   = ($urandom_range(0, 99) < 60);
                b_if.we    = $urandom_range(0, 1) == 1;
                b_if.addr  = 8'($urandom_range(0, 31));
                b_if.wdata = 16'($urandom);
            end
`ifdef DMEM_ARB_LOCK_EN
            b_lock = ($urandom_range(0, 3) == 0);
`endif
            rst = ($urandom_range(0, 199) == 0);
            step();
            a_hold = a_if.req && !exp_ga && !rst;
            b_hold = b_if.req && !exp_gb && !rst;
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
